// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer
// ------------------------------------------------------------------------
// Transaction-level controller for the I2C master. It accepts one command
// (7-bit address, direction, byte count) and drives the start-condition,
// byte-transfer and stop-condition submodules through their flag/complete
// handshakes. It also selects which submodule's open-drain enables reach
// the SCL/SDA pads.
//
// Optional feature: define I2C_SEQ_TIMEOUT_EN to enable the per-phase
// watchdog. A phase that waits TIMEOUT_CYCLES cycles without its complete
// pulses abort, sets timeout_err and finishes the transaction. Without the
// macro, phases wait indefinitely and timeout_err/abort are tied low.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake (addr, rw=1 read, len 0..15)
//   wr_data/wr_data_req     : write byte source; wr_data must be presented
//                             before the request and is consumed on the edge
//                             where wr_data_req is high
//   rd_data/rd_valid        : received byte, one-cycle pulse
//   bus_free                : both lines confirmed released
//   start_*/byte_*/stop_*   : submodule handshakes
//   sub_scl_en/sub_sda_en   : pad enables from start[0], byte[1], stop[2]
//   scl_en/sda_en           : muxed pad enables (1 = release)
//   done/nack_err/timeout_err/abort : end-of-transaction status
// ------------------------------------------------------------------------
module i2c_txn_sequencer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [3:0] cmd_len,
    input  logic [7:0] wr_data,
    output logic       wr_data_req,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       bus_free,
    output logic       start_flag,
    input  logic       start_complete,
    output logic       byte_flag,
    output logic [7:0] byte_tx,
    output logic       byte_rw,
    output logic       byte_mack,
    input  logic       byte_complete,
    input  logic       byte_sack,
    input  logic [7:0] byte_rx,
    output logic       stop_flag,
    input  logic       stop_complete,
    input  logic [2:0] sub_scl_en,
    input  logic [2:0] sub_sda_en,
    output logic       scl_en,
    output logic       sda_en,
    output logic       done,
    output logic       nack_err,
    output logic       timeout_err,
    output logic       abort
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_FREE, S_START, S_ADDR, S_DATA, S_STOP, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [3:0]  remaining_q, remaining_d;
    logic        start_flag_q, start_flag_d;
    logic        byte_flag_q, byte_flag_d;
    logic [7:0]  byte_tx_q, byte_tx_d;
    logic        byte_rw_q, byte_rw_d;
    logic        byte_mack_q, byte_mack_d;
    logic        wr_data_req_q, wr_data_req_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        stop_flag_q, stop_flag_d;
    logic        done_q, done_d;
    logic        nack_err_q, nack_err_d;
    logic        timeout_hit;
    logic        issue_data;
    logic [3:0]  issue_rem;

    // State register (and all other registered outputs / context)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            rw_q          <= 1'b0;
            remaining_q   <= '0;
            start_flag_q  <= 1'b0;
            byte_flag_q   <= 1'b0;
            byte_tx_q     <= '0;
            byte_rw_q     <= 1'b0;
            byte_mack_q   <= 1'b0;
            wr_data_req_q <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            stop_flag_q   <= 1'b0;
            done_q        <= 1'b0;
            nack_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rw_q          <= rw_d;
            remaining_q   <= remaining_d;
            start_flag_q  <= start_flag_d;
            byte_flag_q   <= byte_flag_d;
            byte_tx_q     <= byte_tx_d;
            byte_rw_q     <= byte_rw_d;
            byte_mack_q   <= byte_mack_d;
            wr_data_req_q <= wr_data_req_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            stop_flag_q   <= stop_flag_d;
            done_q        <= done_d;
            nack_err_q    <= nack_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (cmd_valid)      state_d = S_WAIT_FREE;
            S_WAIT_FREE: if (bus_free)       state_d = S_START;
            S_START:     if (start_complete) state_d = S_ADDR;
            S_ADDR: begin
                if (byte_complete) begin
                    if (byte_sack || (remaining_q == 4'd0)) state_d = S_STOP;
                    else                                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // Slave NACK only ends a write; on reads the ACK bit is ours.
                if (byte_complete && ((!rw_q && byte_sack) || (remaining_q == 4'd1)))
                    state_d = S_STOP;
            end
            S_STOP:      if (stop_complete)  state_d = S_DONE;
            S_DONE:                          state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
        if (timeout_hit) state_d = S_DONE;
    end

    // Output / datapath logic: every flag is a one-cycle pulse launched on
    // the same edge as the state change that it accompanies.
    always_comb begin
        addr_d        = addr_q;
        rw_d          = rw_q;
        remaining_d   = remaining_q;
        start_flag_d  = 1'b0;
        byte_flag_d   = 1'b0;
        byte_tx_d     = byte_tx_q;
        byte_rw_d     = byte_rw_q;
        byte_mack_d   = byte_mack_q;
        wr_data_req_d = 1'b0;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        stop_flag_d   = 1'b0;
        done_d        = 1'b0;
        nack_err_d    = nack_err_q;
        issue_data    = 1'b0;
        issue_rem     = remaining_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    rw_d        = cmd_rw;
                    remaining_d = cmd_len;
                    nack_err_d  = 1'b0;
                end
            end
            S_WAIT_FREE: begin
                if (bus_free) start_flag_d = 1'b1;
            end
            S_START: begin
                if (start_complete) begin
                    byte_flag_d = 1'b1;
                    byte_tx_d   = {addr_q, rw_q};
                    byte_rw_d   = 1'b0;
                    byte_mack_d = 1'b0;
                end
            end
            S_ADDR: begin
                if (byte_complete) begin
                    if (byte_sack) begin
                        nack_err_d  = 1'b1;
                        stop_flag_d = 1'b1;
                    end else if (remaining_q == 4'd0) begin
                        stop_flag_d = 1'b1;
                    end else begin
                        issue_data = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (byte_complete) begin
                    if (rw_q) begin
                        rd_data_d  = byte_rx;
                        rd_valid_d = 1'b1;
                    end
                    if (!rw_q && byte_sack) begin
                        nack_err_d  = 1'b1;
                        stop_flag_d = 1'b1;
                    end else begin
                        remaining_d = remaining_q - 4'd1;
                        if (remaining_q == 4'd1) begin
                            stop_flag_d = 1'b1;
                        end else begin
                            issue_data = 1'b1;
                            issue_rem  = remaining_q - 4'd1;
                        end
                    end
                end
            end
            S_STOP: begin
                if (stop_complete) done_d = 1'b1;
            end
            default: ;
        endcase
        if (issue_data) begin
            byte_flag_d = 1'b1;
            if (rw_q) begin
                byte_rw_d   = 1'b1;
                // Master NACKs the last byte it reads.
                byte_mack_d = (issue_rem == 4'd1);
            end else begin
                // wr_data is presented ahead of the request; the request
                // tells the source this byte has been taken.
                byte_tx_d     = wr_data;
                byte_rw_d     = 1'b0;
                byte_mack_d   = 1'b0;
                wr_data_req_d = 1'b1;
            end
        end
        if (timeout_hit) done_d = 1'b1;
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] phase_cnt_q, phase_cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic        abort_q;
    logic        in_phase;
    logic        phase_complete;

    assign in_phase = (state_q == S_START) || (state_q == S_ADDR) ||
                      (state_q == S_DATA)  || (state_q == S_STOP);

    always_comb begin
        phase_complete = 1'b0;
        case (state_q)
            S_START:        phase_complete = start_complete;
            S_ADDR, S_DATA: phase_complete = byte_complete;
            S_STOP:         phase_complete = stop_complete;
            default:        phase_complete = 1'b0;
        endcase
    end

    // A complete arriving on the final count still wins over the timeout.
    assign timeout_hit = in_phase && !phase_complete &&
                         (phase_cnt_q == TIMEOUT_CYCLES - 16'd1);

    always_comb begin
        phase_cnt_d = phase_cnt_q;
        if (start_flag_d || byte_flag_d || stop_flag_d) phase_cnt_d = '0;
        else if (in_phase)                              phase_cnt_d = phase_cnt_q + 16'd1;
        timeout_err_d = timeout_err_q;
        if (state_q == S_IDLE && cmd_valid) timeout_err_d = 1'b0;
        else if (timeout_hit)               timeout_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            phase_cnt_q   <= phase_cnt_d;
            timeout_err_q <= timeout_err_d;
            abort_q       <= timeout_hit;
        end
    end

    assign timeout_err = timeout_err_q;
    assign abort       = abort_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
    assign abort       = 1'b0;
`endif

    // Pad mux decoded straight from the state register.
    always_comb begin
        scl_en = 1'b1;
        sda_en = 1'b1;
        case (state_q)
            S_START: begin
                scl_en = sub_scl_en[0];
                sda_en = sub_sda_en[0];
            end
            S_ADDR, S_DATA: begin
                scl_en = sub_scl_en[1];
                sda_en = sub_sda_en[1];
            end
            S_STOP: begin
                scl_en = sub_scl_en[2];
                sda_en = sub_sda_en[2];
            end
            default: ;
        endcase
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign start_flag  = start_flag_q;
    assign byte_flag   = byte_flag_q;
    assign byte_tx     = byte_tx_q;
    assign byte_rw     = byte_rw_q;
    assign byte_mack   = byte_mack_q;
    assign wr_data_req = wr_data_req_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign stop_flag   = stop_flag_q;
    assign done        = done_q;
    assign nack_err    = nack_err_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Testbench for i2c_txn_sequencer: a table of whole transactions with
// hand-computed expectations, served by a behavioural model of the start,
// byte and stop submodules, plus hand-written sequences for handshake
// timing, pad muxing, mid-transaction reset and (when enabled) timeout.
module tb_i2c_txn_sequencer;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO = 16'd100;
`else
    localparam logic [15:0] TO = 16'd20000;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [3:0] cmd_len = '0;
    logic [7:0] wr_data = '0;
    logic       wr_data_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       bus_free = 1'b1;
    logic       start_flag, start_complete = 1'b0;
    logic       byte_flag;
    logic [7:0] byte_tx;
    logic       byte_rw, byte_mack;
    logic       byte_complete = 1'b0, byte_sack = 1'b0;
    logic [7:0] byte_rx = '0;
    logic       stop_flag, stop_complete = 1'b0;
    logic [2:0] sub_scl_en = 3'b100;   // start 0, byte 0, stop 1
    logic [2:0] sub_sda_en = 3'b010;   // start 0, byte 1, stop 0
    logic       scl_en, sda_en;
    logic       done, nack_err, timeout_err, abort;

    i2c_txn_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rw(cmd_rw), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_data_req(wr_data_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .bus_free(bus_free),
        .start_flag(start_flag), .start_complete(start_complete),
        .byte_flag(byte_flag), .byte_tx(byte_tx), .byte_rw(byte_rw),
        .byte_mack(byte_mack), .byte_complete(byte_complete),
        .byte_sack(byte_sack), .byte_rx(byte_rx),
        .stop_flag(stop_flag), .stop_complete(stop_complete),
        .sub_scl_en(sub_scl_en), .sub_sda_en(sub_sda_en),
        .scl_en(scl_en), .sda_en(sda_en),
        .done(done), .nack_err(nack_err), .timeout_err(timeout_err), .abort(abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  addr;
        logic        rw;
        logic [3:0]  len;
        logic [31:0] data;      // write bytes or slave read bytes, byte i at [8i+:8]
        logic [3:0]  nack_at;   // byte index (0 = address) the slave NACKs; 15 = never
        logic [39:0] exp_tx;    // expected byte_tx per byte_flag pulse
        logic [3:0]  exp_ntx;
        logic [3:0]  exp_wreq;
        logic [31:0] exp_rd;
        logic [3:0]  exp_nrd;
        logic [3:0]  exp_mack;  // per data byte (reads)
        logic        exp_nack;
    } vec_t;

    vec_t vecs [0:5];

    int n_vec = 0;
    int n_err = 0;

    // Shared observation / responder state
    logic [31:0] cur_data = '0;
    int  cur_nack_at = 15;
    int  hold_stop = 0;
    int  cyc = 0;
    int  st_cnt = 0, by_cnt = 0, sp_cnt = 0;
    int  byte_idx = 0, wr_idx = 0, adv_pending = 0;
    int  start_cnt = 0, stop_cnt = 0, ntx = 0, wreq_cnt = 0, nrd = 0;
    int  done_cnt = 0, abort_cnt = 0;
    int  stop_cyc = 0, done_cyc = 0, abort_cyc = 0;
    logic nack_at_done = 1'b0, tout_at_done = 1'b0;
    logic [7:0] tx_obs [0:15];
    logic       rw_obs [0:15];
    logic       mack_obs [0:15];
    logic [7:0] rd_obs [0:3];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        st_cnt = 0; by_cnt = 0; sp_cnt = 0;
        byte_idx = 0; wr_idx = 0; adv_pending = 0;
        start_cnt = 0; stop_cnt = 0; ntx = 0; wreq_cnt = 0; nrd = 0;
        done_cnt = 0; nack_at_done = 1'b0; tout_at_done = 1'b0;
        wr_data = cur_data[7:0];
    endtask

    // sel: 0 byte_flag, 1 stop_flag, 2 done, 3 wr_data_req
    task automatic wait_for(input int sel, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk); #2;
            case (sel)
                0: seen = byte_flag;
                1: seen = stop_flag;
                2: seen = done;
                default: seen = wr_data_req;
            endcase
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_%s: event not seen within 300 cycles", name);
        end
    endtask

    // Submodule model and monitor: runs 1 time unit after each edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            start_complete = 1'b0; byte_complete = 1'b0;
            stop_complete = 1'b0; byte_sack = 1'b0;
            if (adv_pending != 0) begin
                wr_idx++;
                if (wr_idx < 4) wr_data = cur_data[8*wr_idx +: 8];
                adv_pending = 0;
            end
            if (st_cnt > 0) begin
                st_cnt--;
                if (st_cnt == 0) start_complete = 1'b1;
            end
            if (by_cnt > 0) begin
                by_cnt--;
                if (by_cnt == 0) begin
                    byte_complete = 1'b1;
                    byte_sack = (byte_idx == cur_nack_at);
                    if (byte_idx > 0 && byte_idx <= 4) byte_rx = cur_data[8*(byte_idx-1) +: 8];
                    byte_idx++;
                end
            end
            if (sp_cnt > 0) begin
                sp_cnt--;
                if (sp_cnt == 0) stop_complete = 1'b1;
            end
            if (start_flag) begin start_cnt++; st_cnt = 3; end
            if (byte_flag) begin
                if (ntx < 16) begin
                    tx_obs[ntx] = byte_tx; rw_obs[ntx] = byte_rw; mack_obs[ntx] = byte_mack;
                end
                ntx++;
                by_cnt = 3;
            end
            if (stop_flag) begin
                stop_cnt++; stop_cyc = cyc;
                if (hold_stop == 0) sp_cnt = 3;
            end
            if (wr_data_req) begin wreq_cnt++; adv_pending = 1; end
            if (rd_valid) begin
                if (nrd < 4) rd_obs[nrd] = rd_data;
                nrd++;
            end
            if (done) begin
                done_cnt++; done_cyc = cyc;
                nack_at_done = nack_err; tout_at_done = timeout_err;
            end
            if (abort) begin abort_cnt++; abort_cyc = cyc; end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            addr   rw    len   data                              nack   exp_tx                                   ntx   wreq  exp_rd                            nrd   mack     nack
        vecs[0] = '{7'h50, 1'b0, 4'd2, {8'h00,8'h00,8'h3C,8'hA5}, 4'd15, {8'h00,8'h00,8'h3C,8'hA5,8'hA0}, 4'd3, 4'd2, 32'h0,                      4'd0, 4'b0000, 1'b0};
        vecs[1] = '{7'h68, 1'b1, 4'd3, {8'h00,8'h33,8'h22,8'h11}, 4'd15, {8'h00,8'h00,8'h00,8'h00,8'hD1}, 4'd4, 4'd0, {8'h00,8'h33,8'h22,8'h11}, 4'd3, 4'b0100, 1'b0};
        vecs[2] = '{7'h2A, 1'b0, 4'd4, {8'h44,8'h33,8'h22,8'h11}, 4'd0,  {8'h00,8'h00,8'h00,8'h00,8'h54}, 4'd1, 4'd0, 32'h0,                      4'd0, 4'b0000, 1'b1};
        vecs[3] = '{7'h3F, 1'b0, 4'd0, 32'h0,                     4'd15, {8'h00,8'h00,8'h00,8'h00,8'h7E}, 4'd1, 4'd0, 32'h0,                      4'd0, 4'b0000, 1'b0};
        vecs[4] = '{7'h10, 1'b0, 4'd3, {8'h00,8'h03,8'h02,8'h01}, 4'd2,  {8'h00,8'h00,8'h02,8'h01,8'h20}, 4'd3, 4'd2, 32'h0,                      4'd0, 4'b0000, 1'b1};
        vecs[5] = '{7'h7F, 1'b1, 4'd1, {8'h00,8'h00,8'h00,8'h9C}, 4'd15, {8'h00,8'h00,8'h00,8'h00,8'hFF}, 4'd2, 4'd0, {8'h00,8'h00,8'h00,8'h9C}, 4'd1, 4'b0001, 1'b0};

        // ---- reset values
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_pads", {scl_en, sda_en}, 2'b11);
        check("rst_flags", {start_flag, byte_flag, stop_flag, wr_data_req, rd_valid}, 0);
        check("rst_status", {done, nack_err, timeout_err, abort}, 0);
        check("rst_data", {byte_tx, rd_data}, 0);
        reset = 1'b0;

        // ---- handshake timing, bus_free wait, pad mux, cmd_valid held while busy
        cur_data = '0; cur_nack_at = 15; clear_obs();
        bus_free = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 7'h3F; cmd_rw = 1'b0; cmd_len = 4'd0;
        @(posedge clk); #2;
        check("hs_ready_drops", cmd_ready, 0);
        check("hs_no_start_yet", start_flag, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #2;
            check("wf_start_held", start_flag, 0);
            check("wf_pads", {scl_en, sda_en}, 2'b11);
        end
        bus_free = 1'b1;
        @(posedge clk); #2;
        check("wf_start_flag", start_flag, 1);
        check("pad_start", {scl_en, sda_en}, 2'b00);
        cmd_valid = 1'b0;
        wait_for(0, "addr_byte");
        check("pad_byte", {scl_en, sda_en}, 2'b01);
        wait_for(1, "stop");
        check("pad_stop", {scl_en, sda_en}, 2'b10);
        wait_for(2, "done");
        check("done_ready_low", cmd_ready, 0);
        check("done_pads", {scl_en, sda_en}, 2'b11);
        @(posedge clk); #2;
        check("post_done_ready", cmd_ready, 1);
        check("post_done_pulse", done, 0);
        check("busy_cmd_ignored", start_cnt, 1);

        // ---- table of transactions
        for (int k = 0; k < 6; k++) begin
            vec_t v;
            logic exp_rw;
            v = vecs[k];
            cur_data = v.data; cur_nack_at = int'(v.nack_at); clear_obs();
            cmd_valid = 1'b1; cmd_addr = v.addr; cmd_rw = v.rw; cmd_len = v.len;
            @(posedge clk); #2;
            cmd_valid = 1'b0;
            wait_for(2, $sformatf("v%0d_done", k));
            @(posedge clk); #2;
            check($sformatf("v%0d_nbytes", k), ntx, v.exp_ntx);
            for (int i = 0; i < 5; i++) begin
                if (i < int'(v.exp_ntx) && i < ntx) begin
                    exp_rw = (i > 0) && v.rw;
                    if (!exp_rw) check($sformatf("v%0d_tx%0d", k, i), tx_obs[i], v.exp_tx[8*i +: 8]);
                    check($sformatf("v%0d_rw%0d", k, i), rw_obs[i], exp_rw);
                    if (exp_rw) check($sformatf("v%0d_mack%0d", k, i), mack_obs[i], v.exp_mack[i-1]);
                end
            end
            check($sformatf("v%0d_wreq", k), wreq_cnt, v.exp_wreq);
            check($sformatf("v%0d_nrd", k), nrd, v.exp_nrd);
            for (int i = 0; i < 4; i++)
                if (i < int'(v.exp_nrd) && i < nrd)
                    check($sformatf("v%0d_rd%0d", k, i), rd_obs[i], v.exp_rd[8*i +: 8]);
            check($sformatf("v%0d_nack", k), nack_at_done, v.exp_nack);
            check($sformatf("v%0d_counts", k), {start_cnt[3:0], stop_cnt[3:0], done_cnt[3:0]}, 12'h111);
        end

        // ---- reset while in DATA
        cur_data = {8'h0D, 8'h0C, 8'h0B, 8'h0A}; cur_nack_at = 15; clear_obs();
        cmd_valid = 1'b1; cmd_addr = 7'h22; cmd_rw = 1'b0; cmd_len = 4'd4;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        wait_for(3, "mid_wreq");
        reset = 1'b1;
        @(posedge clk); #2;
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_pads", {scl_en, sda_en}, 2'b11);
        check("mid_rst_flags", {start_flag, byte_flag, stop_flag, wr_data_req, done}, 0);
        check("mid_rst_tx", byte_tx, 0);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        check("mid_rst_no_done", done_cnt, 0);
        check("mid_rst_no_stop", stop_cnt, 0);
        check("mid_rst_idle", cmd_ready, 1);

`ifdef I2C_SEQ_TIMEOUT_EN
        // ---- stop_complete withheld: timeout 100 cycles after stop_flag
        cur_data = '0; cur_nack_at = 15; clear_obs();
        hold_stop = 1;
        cmd_valid = 1'b1; cmd_addr = 7'h3F; cmd_rw = 1'b0; cmd_len = 4'd0;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        wait_for(1, "to_stop");
        wait_for(2, "to_done");
        check("to_abort", abort, 1);
        check("to_err", timeout_err, 1);
        check("to_pads", {scl_en, sda_en}, 2'b11);
        check("to_delay", done_cyc - stop_cyc, 100);
        check("to_abort_with_done", abort_cyc, done_cyc);
        hold_stop = 0;
        @(posedge clk); #2;
        check("to_abort_pulse", abort, 0);
`else
        check("no_abort_ever", abort_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
